// File: rtl/cache_line_controller_pkg.sv
// Shared types for the cache line controller.
// State enum, statistics bit indices, beat width helper.
package cache_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_WRITEBACK,
    S_FILL,
    S_INSTALL,
    S_WT_WRITE,
    S_RESPOND
  } state_t;

  localparam int CNT_READ      = 0;
  localparam int CNT_WRITE     = 1;
  localparam int CNT_HIT       = 2;
  localparam int CNT_MISS      = 3;
  localparam int CNT_WRITEBACK = 4;
  localparam int CNT_W         = 5;

  function automatic int beat_width(input int words);
    return (words <= 1) ? 1 : $clog2(words);
  endfunction

endpackage

// File: rtl/cache_line_controller_beat_counter.sv
// Beat counter for multi-beat hmem line transfers.
// Ports: clk, reset_n, load_zero, inc -> beat, last.
module cache_beat_counter
  import cache_ctrl_pkg::*;
#(
  parameter int WORDS = 4,
  parameter int BW    = beat_width(WORDS)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          load_zero,
  input  logic          inc,
  output logic [BW-1:0] beat,
  output logic          last
);

  localparam logic [BW-1:0] LAST = BW'(WORDS - 1);

  logic [BW-1:0] cnt;

  // Never steps past the last beat, so a
  // one-word line keeps the count at zero.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load_zero) begin
      cnt <= '0;
    end else if (inc && !last) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign beat = cnt;
  assign last = (cnt == LAST);

endmodule

// File: rtl/cache_line_controller.sv
// Cache controller FSM: CPU request, datapath strobes, hmem line moves.
// Ports: req_*, datapath flags/strobes, hmem_*, beat_index, count_event.
module cache_line_controller
  import cache_ctrl_pkg::*;
#(
  parameter int  WORDS_PER_LINE = 4,
  parameter int  WRITE_THROUGH  = 0,
  parameter int  WRITE_ALLOCATE = 1,
  localparam int BW = beat_width(WORDS_PER_LINE)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          req_valid,
  input  logic          req_is_write,
  output logic          req_ready,
  output logic          req_done,
  input  logic          valid_block_match,
  input  logic          valid_dirty_bit,
  output logic          hmem_req,
  output logic          hmem_we,
  input  logic          hmem_ack,
  output logic [BW-1:0] beat_index,
  output logic          miss_recovery_mode,
  output logic          process_lru_counters,
  output logic          set_selected_dirty_bit,
  output logic          clear_selected_dirty_bit,
  output logic          clear_selected_valid_bit,
  output logic          perform_write,
  output logic          finish_new_line_install,
  output logic          set_hmem_block_address,
  output logic          use_victim_tag_for_hmem_block_address,
  output logic [4:0]    count_event
);

  localparam bit WT = (WRITE_THROUGH != 0);
  localparam bit WA = (WRITE_ALLOCATE != 0);

  state_t        state;
  state_t        state_next;
  logic          op_write;
  logic          replay;
  logic [BW-1:0] beat;
  logic          beat_last;
  logic          beat_clr;
  logic          beat_inc;
  logic          in_line_xfer;

  // Lookup outcome, one-hot
  logic lk_hit;
  logic lk_bypass;
  logic lk_wb;
  logic lk_fill;

  assign lk_hit    = valid_block_match;
  assign lk_bypass = !lk_hit && op_write && !WA;
  assign lk_wb     = !lk_hit && !lk_bypass
                   && valid_dirty_bit && !WT;
  assign lk_fill   = !lk_hit && !lk_bypass && !lk_wb;

  assign in_line_xfer = (state == S_WRITEBACK)
                     || (state == S_FILL);

  assign beat_inc = in_line_xfer && hmem_ack;
  assign beat_clr =
    ((state == S_LOOKUP) && (lk_wb || lk_fill))
    || (beat_inc && beat_last);

  cache_beat_counter #(
    .WORDS (WORDS_PER_LINE),
    .BW    (BW)
  ) u_beat (
    .clk       (clk),
    .reset_n   (reset_n),
    .load_zero (beat_clr),
    .inc       (beat_inc),
    .beat      (beat),
    .last      (beat_last)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      op_write <= 1'b0;
      replay   <= 1'b0;
    end else if (state == S_IDLE) begin
      if (req_valid) begin
        op_write <= req_is_write;
        replay   <= 1'b0;
      end
    end else if (state == S_INSTALL) begin
      replay <= 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: begin
        if (req_valid) state_next = S_LOOKUP;
      end
      S_LOOKUP: begin
        unique case (1'b1)
          lk_hit: begin
            state_next = (op_write && WT)
                       ? S_WT_WRITE : S_RESPOND;
          end
          lk_bypass: state_next = S_WT_WRITE;
          lk_wb:     state_next = S_WRITEBACK;
          lk_fill:   state_next = S_FILL;
          default:   state_next = S_FILL;
        endcase
      end
      S_WRITEBACK: begin
        if (hmem_ack && beat_last) state_next = S_FILL;
      end
      S_FILL: begin
        if (hmem_ack && beat_last) state_next = S_INSTALL;
      end
      S_INSTALL: state_next = S_LOOKUP;
      S_WT_WRITE: begin
        if (hmem_ack) state_next = S_RESPOND;
      end
      S_RESPOND: state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready                             = 1'b0;
    req_done                              = 1'b0;
    hmem_req                              = 1'b0;
    hmem_we                               = 1'b0;
    miss_recovery_mode                    = 1'b0;
    process_lru_counters                  = 1'b0;
    set_selected_dirty_bit                = 1'b0;
    clear_selected_dirty_bit              = 1'b0;
    clear_selected_valid_bit              = 1'b0;
    perform_write                         = 1'b0;
    finish_new_line_install               = 1'b0;
    set_hmem_block_address                = 1'b0;
    use_victim_tag_for_hmem_block_address = 1'b0;
    count_event                           = '0;
    unique case (state)
      S_IDLE: req_ready = 1'b1;
      S_LOOKUP: begin
        // The replay after a fill is not a new access
        if (!replay) begin
          count_event[CNT_READ]  = !op_write;
          count_event[CNT_WRITE] = op_write;
          count_event[CNT_HIT]   = lk_hit;
          count_event[CNT_MISS]  = !lk_hit;
        end
        unique case (1'b1)
          lk_hit: begin
            process_lru_counters   = 1'b1;
            perform_write          = op_write;
            set_selected_dirty_bit = op_write && !WT;
          end
          lk_bypass: begin
            set_hmem_block_address = 1'b1;
          end
          lk_wb: begin
            set_hmem_block_address                = 1'b1;
            use_victim_tag_for_hmem_block_address = 1'b1;
            count_event[CNT_WRITEBACK]            = 1'b1;
          end
          lk_fill: begin
            set_hmem_block_address   = 1'b1;
            clear_selected_valid_bit = 1'b1;
          end
          default: ;
        endcase
      end
      S_WRITEBACK: begin
        hmem_req           = 1'b1;
        hmem_we            = 1'b1;
        miss_recovery_mode = 1'b1;
        if (hmem_ack && beat_last) begin
          clear_selected_dirty_bit = 1'b1;
          clear_selected_valid_bit = 1'b1;
          set_hmem_block_address   = 1'b1;
        end
      end
      S_FILL: begin
        hmem_req           = 1'b1;
        miss_recovery_mode = 1'b1;
        perform_write      = hmem_ack;
      end
      S_INSTALL: begin
        miss_recovery_mode      = 1'b1;
        finish_new_line_install = 1'b1;
      end
      S_WT_WRITE: begin
        hmem_req = 1'b1;
        hmem_we  = 1'b1;
      end
      S_RESPOND: req_done = 1'b1;
      default: ;
    endcase
  end

  assign beat_index = (state == S_WT_WRITE) ? '0 : beat;

endmodule

// File: tb/tb_cache_line_controller.sv
// Directed bench for cache_line_controller.
// Three instances cover write-back, write-through/no-allocate, one-word lines.
module tb_cache_line_controller;

  localparam logic [12:0] RDY  = 13'h1000;
  localparam logic [12:0] DONE = 13'h0800;
  localparam logic [12:0] HREQ = 13'h0400;
  localparam logic [12:0] HWE  = 13'h0200;
  localparam logic [12:0] MRM  = 13'h0100;
  localparam logic [12:0] LRU  = 13'h0080;
  localparam logic [12:0] SETD = 13'h0040;
  localparam logic [12:0] CLRD = 13'h0020;
  localparam logic [12:0] CLRV = 13'h0010;
  localparam logic [12:0] PW   = 13'h0008;
  localparam logic [12:0] FIN  = 13'h0004;
  localparam logic [12:0] SETH = 13'h0002;
  localparam logic [12:0] VIC  = 13'h0001;

  logic clk = 1'b0;
  logic reset_n;
  logic rv_a, rv_b, rv_c;
  logic rw, vbm, vdb, ack;

  logic       o_rdy  [3];
  logic       o_done [3];
  logic       o_hreq [3];
  logic       o_hwe  [3];
  logic       o_mrm  [3];
  logic       o_lru  [3];
  logic       o_setd [3];
  logic       o_clrd [3];
  logic       o_clrv [3];
  logic       o_pw   [3];
  logic       o_fin  [3];
  logic       o_seth [3];
  logic       o_vic  [3];
  logic [4:0] o_ev   [3];
  logic [1:0] a_bi, b_bi;
  logic       c_bi;

  logic [12:0] sa, sb, sc;
  logic [19:0] va, vb;
  logic [18:0] vc;
  logic [19:0] exp;
  logic [18:0] expc;

  int npass = 0;
  int nfail = 0;
  int ev_a [5] = '{0, 0, 0, 0, 0};
  int setd_b = 0;
  int clrv_b = 0;
  int hreq_b = 0;
  int base [5];
  int base_s, base_v, base_h;

  always #5 clk = ~clk;

  assign sa = {o_rdy[0], o_done[0], o_hreq[0], o_hwe[0],
               o_mrm[0], o_lru[0], o_setd[0], o_clrd[0],
               o_clrv[0], o_pw[0], o_fin[0], o_seth[0],
               o_vic[0]};
  assign sb = {o_rdy[1], o_done[1], o_hreq[1], o_hwe[1],
               o_mrm[1], o_lru[1], o_setd[1], o_clrd[1],
               o_clrv[1], o_pw[1], o_fin[1], o_seth[1],
               o_vic[1]};
  assign sc = {o_rdy[2], o_done[2], o_hreq[2], o_hwe[2],
               o_mrm[2], o_lru[2], o_setd[2], o_clrd[2],
               o_clrv[2], o_pw[2], o_fin[2], o_seth[2],
               o_vic[2]};
  assign va = {sa, o_ev[0], a_bi};
  assign vb = {sb, o_ev[1], b_bi};
  assign vc = {sc, o_ev[2], c_bi};

  always @(posedge clk) begin
    for (int b = 0; b < 5; b++)
      if (o_ev[0][b]) ev_a[b] <= ev_a[b] + 1;
    if (o_setd[1]) setd_b <= setd_b + 1;
    if (o_clrv[1]) clrv_b <= clrv_b + 1;
    if (o_hreq[1]) hreq_b <= hreq_b + 1;
  end

  cache_line_controller #(
    .WORDS_PER_LINE(4), .WRITE_THROUGH(0), .WRITE_ALLOCATE(1)
  ) u_a (
    .clk(clk), .reset_n(reset_n),
    .req_valid(rv_a), .req_is_write(rw),
    .req_ready(o_rdy[0]), .req_done(o_done[0]),
    .valid_block_match(vbm), .valid_dirty_bit(vdb),
    .hmem_req(o_hreq[0]), .hmem_we(o_hwe[0]), .hmem_ack(ack),
    .beat_index(a_bi), .miss_recovery_mode(o_mrm[0]),
    .process_lru_counters(o_lru[0]),
    .set_selected_dirty_bit(o_setd[0]),
    .clear_selected_dirty_bit(o_clrd[0]),
    .clear_selected_valid_bit(o_clrv[0]),
    .perform_write(o_pw[0]),
    .finish_new_line_install(o_fin[0]),
    .set_hmem_block_address(o_seth[0]),
    .use_victim_tag_for_hmem_block_address(o_vic[0]),
    .count_event(o_ev[0])
  );

  cache_line_controller #(
    .WORDS_PER_LINE(4), .WRITE_THROUGH(1), .WRITE_ALLOCATE(0)
  ) u_b (
    .clk(clk), .reset_n(reset_n),
    .req_valid(rv_b), .req_is_write(rw),
    .req_ready(o_rdy[1]), .req_done(o_done[1]),
    .valid_block_match(vbm), .valid_dirty_bit(vdb),
    .hmem_req(o_hreq[1]), .hmem_we(o_hwe[1]), .hmem_ack(ack),
    .beat_index(b_bi), .miss_recovery_mode(o_mrm[1]),
    .process_lru_counters(o_lru[1]),
    .set_selected_dirty_bit(o_setd[1]),
    .clear_selected_dirty_bit(o_clrd[1]),
    .clear_selected_valid_bit(o_clrv[1]),
    .perform_write(o_pw[1]),
    .finish_new_line_install(o_fin[1]),
    .set_hmem_block_address(o_seth[1]),
    .use_victim_tag_for_hmem_block_address(o_vic[1]),
    .count_event(o_ev[1])
  );

  cache_line_controller #(
    .WORDS_PER_LINE(1), .WRITE_THROUGH(0), .WRITE_ALLOCATE(1)
  ) u_c (
    .clk(clk), .reset_n(reset_n),
    .req_valid(rv_c), .req_is_write(rw),
    .req_ready(o_rdy[2]), .req_done(o_done[2]),
    .valid_block_match(vbm), .valid_dirty_bit(vdb),
    .hmem_req(o_hreq[2]), .hmem_we(o_hwe[2]), .hmem_ack(ack),
    .beat_index(c_bi), .miss_recovery_mode(o_mrm[2]),
    .process_lru_counters(o_lru[2]),
    .set_selected_dirty_bit(o_setd[2]),
    .clear_selected_dirty_bit(o_clrd[2]),
    .clear_selected_valid_bit(o_clrv[2]),
    .perform_write(o_pw[2]),
    .finish_new_line_install(o_fin[2]),
    .set_hmem_block_address(o_seth[2]),
    .use_victim_tag_for_hmem_block_address(o_vic[2]),
    .count_event(o_ev[2])
  );

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (2) next_cycle;
    @(negedge clk);
    exp = {RDY, 5'b0, 2'd0};
    if (va !== exp) begin
      nfail++; $display("FAIL rst_a got=%h exp=%h", va, exp);
    end else npass++;
    if (vb !== exp) begin
      nfail++; $display("FAIL rst_b got=%h exp=%h", vb, exp);
    end else npass++;
    expc = {RDY, 5'b0, 1'b0};
    if (vc !== expc) begin
      nfail++; $display("FAIL rst_c got=%h exp=%h", vc, expc);
    end else npass++;
    next_cycle;
    reset_n = 1'b1;
    ack = 1'b1;
    @(negedge clk);
    if (va !== exp) begin
      nfail++; $display("FAIL idle_ack0 got=%h exp=%h", va, exp);
    end else npass++;
    next_cycle;
    @(negedge clk);
    if (va !== exp) begin
      nfail++; $display("FAIL idle_ack1 got=%h exp=%h", va, exp);
    end else npass++;
    ack = 1'b0;
  endtask

  task automatic test_read_hit;
    next_cycle;
    rv_a = 1'b1; rw = 1'b0; vbm = 1'b1; vdb = 1'b0; ack = 1'b0;
    @(negedge clk);
    exp = {RDY, 5'b0, 2'd0};
    if (va !== exp) begin
      nfail++; $display("FAIL rh_idle got=%h exp=%h", va, exp);
    end else npass++;
    next_cycle;
    rv_a = 1'b0;
    @(negedge clk);
    exp = {LRU, 5'b00101, 2'd0};
    if (va !== exp) begin
      nfail++; $display("FAIL rh_lookup got=%h exp=%h", va, exp);
    end else npass++;
    next_cycle;
    @(negedge clk);
    exp = {DONE, 5'b0, 2'd0};
    if (va !== exp) begin
      nfail++; $display("FAIL rh_respond got=%h exp=%h", va, exp);
    end else npass++;
    next_cycle;
    @(negedge clk);
    exp = {RDY, 5'b0, 2'd0};
    if (va !== exp) begin
      nfail++; $display("FAIL rh_back got=%h exp=%h", va, exp);
    end else npass++;
  endtask

  task automatic test_wb_miss;
    next_cycle;
    for (int b = 0; b < 5; b++) base[b] = ev_a[b];
    rv_a = 1'b1; rw = 1'b1; vbm = 1'b0; vdb = 1'b1; ack = 1'b0;
    next_cycle;
    rv_a = 1'b0;
    @(negedge clk);
    exp = {SETH | VIC, 5'b11010, 2'd0};
    if (va !== exp) begin
      nfail++; $display("FAIL wm_lookup got=%h exp=%h", va, exp);
    end else npass++;
    for (int i = 0; i < 4; i++) begin
      next_cycle;
      ack = 1'b0;
      @(negedge clk);
      exp = {HREQ | HWE | MRM, 5'b0, 2'(i)};
      if (va !== exp) begin
        nfail++; $display("FAIL wb_wait%0d got=%h exp=%h", i, va, exp);
      end else npass++;
      next_cycle;
      ack = 1'b1;
      @(negedge clk);
      if (i == 3) exp = {HREQ | HWE | MRM | CLRD | CLRV | SETH, 5'b0, 2'd3};
      else exp = {HREQ | HWE | MRM, 5'b0, 2'(i)};
      if (va !== exp) begin
        nfail++; $display("FAIL wb_ack%0d got=%h exp=%h", i, va, exp);
      end else npass++;
    end
    next_cycle;
    for (int i = 0; i < 4; i++) begin
      ack = 1'b1;
      @(negedge clk);
      exp = {HREQ | MRM | PW, 5'b0, 2'(i)};
      if (va !== exp) begin
        nfail++; $display("FAIL fill%0d got=%h exp=%h", i, va, exp);
      end else npass++;
      next_cycle;
    end
    ack = 1'b0; vbm = 1'b1; vdb = 1'b0;
    @(negedge clk);
    exp = {MRM | FIN, 5'b0, 2'd0};
    if (va !== exp) begin
      nfail++; $display("FAIL wm_install got=%h exp=%h", va, exp);
    end else npass++;
    next_cycle;
    @(negedge clk);
    exp = {LRU | PW | SETD, 5'b0, 2'd0};
    if (va !== exp) begin
      nfail++; $display("FAIL wm_replay got=%h exp=%h", va, exp);
    end else npass++;
    next_cycle;
    @(negedge clk);
    exp = {DONE, 5'b0, 2'd0};
    if (va !== exp) begin
      nfail++; $display("FAIL wm_respond got=%h exp=%h", va, exp);
    end else npass++;
    next_cycle;
    @(negedge clk);
    if (ev_a[0] - base[0] !== 0 || ev_a[1] - base[1] !== 1
        || ev_a[2] - base[2] !== 0 || ev_a[3] - base[3] !== 1
        || ev_a[4] - base[4] !== 1) begin
      nfail++;
      $display("FAIL wm_counts got rd=%0d wr=%0d hit=%0d miss=%0d wb=%0d exp 0 1 0 1 1",
               ev_a[0] - base[0], ev_a[1] - base[1], ev_a[2] - base[2],
               ev_a[3] - base[3], ev_a[4] - base[4]);
    end else npass++;
  endtask

  task automatic test_wt_hit;
    next_cycle;
    base_s = setd_b;
    rv_b = 1'b1; rw = 1'b1; vbm = 1'b1; vdb = 1'b0; ack = 1'b0;
    next_cycle;
    rv_b = 1'b0;
    @(negedge clk);
    exp = {LRU | PW, 5'b00110, 2'd0};
    if (vb !== exp) begin
      nfail++; $display("FAIL wt_lookup got=%h exp=%h", vb, exp);
    end else npass++;
    next_cycle;
    @(negedge clk);
    exp = {HREQ | HWE, 5'b0, 2'd0};
    if (vb !== exp) begin
      nfail++; $display("FAIL wt_wait got=%h exp=%h", vb, exp);
    end else npass++;
    next_cycle;
    ack = 1'b1;
    @(negedge clk);
    if (vb !== exp) begin
      nfail++; $display("FAIL wt_ack got=%h exp=%h", vb, exp);
    end else npass++;
    next_cycle;
    ack = 1'b0;
    @(negedge clk);
    exp = {DONE, 5'b0, 2'd0};
    if (vb !== exp) begin
      nfail++; $display("FAIL wt_respond got=%h exp=%h", vb, exp);
    end else npass++;
    next_cycle;
    @(negedge clk);
    if (setd_b !== base_s) begin
      nfail++; $display("FAIL wt_no_dirty got=%0d exp=%0d", setd_b, base_s);
    end else npass++;
  endtask

  task automatic test_no_alloc;
    next_cycle;
    base_v = clrv_b;
    base_h = hreq_b;
    rv_b = 1'b1; rw = 1'b1; vbm = 1'b0; vdb = 1'b1; ack = 1'b0;
    next_cycle;
    rv_b = 1'b0;
    @(negedge clk);
    exp = {SETH, 5'b01010, 2'd0};
    if (vb !== exp) begin
      nfail++; $display("FAIL na_lookup got=%h exp=%h", vb, exp);
    end else npass++;
    next_cycle;
    ack = 1'b1;
    @(negedge clk);
    exp = {HREQ | HWE, 5'b0, 2'd0};
    if (vb !== exp) begin
      nfail++; $display("FAIL na_beat got=%h exp=%h", vb, exp);
    end else npass++;
    next_cycle;
    ack = 1'b0;
    @(negedge clk);
    exp = {DONE, 5'b0, 2'd0};
    if (vb !== exp) begin
      nfail++; $display("FAIL na_respond got=%h exp=%h", vb, exp);
    end else npass++;
    next_cycle;
    @(negedge clk);
    if (clrv_b !== base_v || hreq_b - base_h !== 1) begin
      nfail++;
      $display("FAIL na_counts got clrv=%0d beats=%0d exp clrv=0 beats=1",
               clrv_b - base_v, hreq_b - base_h);
    end else npass++;
  endtask

  task automatic test_single_word;
    next_cycle;
    rv_c = 1'b1; rw = 1'b0; vbm = 1'b0; vdb = 1'b0; ack = 1'b0;
    next_cycle;
    rv_c = 1'b0;
    @(negedge clk);
    expc = {SETH | CLRV, 5'b01001, 1'b0};
    if (vc !== expc) begin
      nfail++; $display("FAIL sw_lookup got=%h exp=%h", vc, expc);
    end else npass++;
    next_cycle;
    ack = 1'b1;
    @(negedge clk);
    expc = {HREQ | MRM | PW, 5'b0, 1'b0};
    if (vc !== expc) begin
      nfail++; $display("FAIL sw_fill got=%h exp=%h", vc, expc);
    end else npass++;
    next_cycle;
    ack = 1'b0; vbm = 1'b1;
    @(negedge clk);
    expc = {MRM | FIN, 5'b0, 1'b0};
    if (vc !== expc) begin
      nfail++; $display("FAIL sw_install got=%h exp=%h", vc, expc);
    end else npass++;
    next_cycle;
    @(negedge clk);
    expc = {LRU, 5'b0, 1'b0};
    if (vc !== expc) begin
      nfail++; $display("FAIL sw_replay got=%h exp=%h", vc, expc);
    end else npass++;
    next_cycle;
    @(negedge clk);
    expc = {DONE, 5'b0, 1'b0};
    if (vc !== expc) begin
      nfail++; $display("FAIL sw_respond got=%h exp=%h", vc, expc);
    end else npass++;
    next_cycle;
    @(negedge clk);
    expc = {RDY, 5'b0, 1'b0};
    if (vc !== expc) begin
      nfail++; $display("FAIL sw_idle got=%h exp=%h", vc, expc);
    end else npass++;
  endtask

  task automatic test_reset_mid_fill;
    next_cycle;
    rv_a = 1'b1; rw = 1'b0; vbm = 1'b0; vdb = 1'b0; ack = 1'b0;
    next_cycle;
    rv_a = 1'b0;
    @(negedge clk);
    exp = {SETH | CLRV, 5'b01001, 2'd0};
    if (va !== exp) begin
      nfail++; $display("FAIL rf_lookup got=%h exp=%h", va, exp);
    end else npass++;
    next_cycle;
    ack = 1'b1;
    @(negedge clk);
    exp = {HREQ | MRM | PW, 5'b0, 2'd0};
    if (va !== exp) begin
      nfail++; $display("FAIL rf_beat0 got=%h exp=%h", va, exp);
    end else npass++;
    next_cycle;
    ack = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    exp = {HREQ | MRM, 5'b0, 2'd1};
    if (va !== exp) begin
      nfail++; $display("FAIL rf_beat1 got=%h exp=%h", va, exp);
    end else npass++;
    next_cycle;
    reset_n = 1'b1;
    @(negedge clk);
    exp = {RDY, 5'b0, 2'd0};
    if (va !== exp) begin
      nfail++; $display("FAIL rf_after got=%h exp=%h", va, exp);
    end else npass++;
  endtask

  initial begin
    reset_n = 1'b0;
    rv_a = 1'b0; rv_b = 1'b0; rv_c = 1'b0;
    rw = 1'b0; vbm = 1'b0; vdb = 1'b0; ack = 1'b0;
    test_reset;
    test_read_hit;
    test_wb_miss;
    test_wt_hit;
    test_no_alloc;
    test_single_word;
    test_reset_mid_fill;
    test_read_hit;
    $display("%0d/%0d checks passed", npass, npass + nfail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
